// File: rtl/tdc_thermo_decoder.sv
// TDC back-end: thermometer snapshot -> bubble-tolerant fine count, combined with a
// free-running coarse counter into timestamps, queued in a FIFO behind a valid/ready port.
module tdc_thermo_decoder #(
    parameter int TAPS     = 4,
    parameter int COARSE_W = 8,
    parameter int DEPTH    = 4,
    localparam int FINE_W  = $clog2(TAPS + 1)
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [TAPS-1:0]            THERM,
    input  logic                       THERM_VLD,
    output logic [COARSE_W-1:0]        COARSE,
    output logic [COARSE_W+FINE_W-1:0] TS_DATA,
    output logic                       TS_BUBBLE,
    output logic                       TS_VALID,
    input  logic                       TS_READY,
    output logic [7:0]                 DROP_CNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = COARSE_W + FINE_W + 1;

    logic [COARSE_W-1:0] coarse_q;
    logic                s1_vld;
    logic [COARSE_W-1:0] s1_coarse;
    logic [FINE_W-1:0]   s1_fine;
    logic                s1_bubble;

    logic [FINE_W-1:0]   fine_c;
    logic                bubble_c;
    logic [TAPS:0]       therm_ext;

    logic [EW-1:0]       mem [DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic [7:0]          drop_q;
    logic                empty, full, pop, push, drop;
    logic [EW-1:0]       head;

    // Popcount absorbs bubbles; a valid thermometer code has no carry-overlap with itself + 1.
    always_comb begin
        fine_c = '0;
        for (int unsigned i = 0; i < TAPS; i++) begin
            fine_c = fine_c + FINE_W'(THERM[i]);
        end
        therm_ext = {1'b0, THERM};
        bubble_c  = |(therm_ext & (therm_ext + {{TAPS{1'b0}}, 1'b1}));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            coarse_q  <= '0;
            s1_vld    <= 1'b0;
            s1_coarse <= '0;
            s1_fine   <= '0;
            s1_bubble <= 1'b0;
        end else begin
            coarse_q <= coarse_q + COARSE_W'(1);
            s1_vld   <= THERM_VLD;
            if (THERM_VLD) begin
                s1_coarse <= coarse_q;
                s1_fine   <= fine_c;
                s1_bubble <= bubble_c;
            end
        end
    end

    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop   = !empty && TS_READY;
        push  = s1_vld && (!full || pop);
        drop  = s1_vld && full && !pop;
        head  = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {s1_coarse, s1_fine, s1_bubble};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            drop_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    // Head is masked while empty so stale memory never shows (memory itself is not reset).
    assign COARSE    = coarse_q;
    assign TS_VALID  = !empty;
    assign TS_DATA   = empty ? '0 : head[EW-1:1];
    assign TS_BUBBLE = !empty && head[0];
    assign DROP_CNT  = drop_q;

endmodule

// File: doc/tdc_thermo_decoder.md
# tdc_thermo_decoder

Back-end reader for the TDC delay line. Takes the latched thermometer snapshot of the delay-line taps on each hit and converts it to a fine-time count with bubble tolerance. Combines the fine count with a free-running coarse counter into a timestamp, buffers timestamps in a small FIFO and hands them downstream over a valid/ready handshake. Sits between the delay line and the readout/serialiser logic.

## Interface
- TAPS, 4: number of delay-line taps (thermometer width), 2..16.
- COARSE_W, 8: coarse counter width.
- DEPTH, 4: FIFO entries, power of two, ≥2.
- FINE_W, derived = clog2(TAPS+1): fine-count width (3 for TAPS=4).
- CLK  input  1  sole clock, all logic on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- THERM  input  TAPS  tap snapshot from the delay line, bit 0 = first tap.
- THERM_VLD  input  1  one-cycle strobe, THERM is a valid hit snapshot.
- COARSE  output  COARSE_W  current coarse counter value.
- TS_DATA  output  COARSE_W+FINE_W  timestamp {coarse, fine} at FIFO head.
- TS_BUBBLE  output  1  head entry had a non-thermometer (bubbled) pattern.
- TS_VALID  output  1  FIFO non-empty, head entry presented.
- TS_READY  input  1  downstream accepts head entry.
- DROP_CNT  output  8  hits lost to FIFO full, saturating.

## Operation
- Coarse counter: increments every edge, wraps from 2^COARSE_W−1 to 0.
- Stage 1 (capture): on an edge where THERM_VLD=1:
  - register fine = popcount(THERM), which corrects bubbles;
  - register bubble = 1 if THERM is not of the form 0…01…1 (ones contiguous from bit 0);
  - register coarse = COARSE value before that edge;
  - set stage-1 valid. Otherwise stage-1 valid=0.
- Stage 2 (write): on the next edge, if stage-1 valid, push {coarse, fine, bubble} into the FIFO.
  - Not full: entry written.
  - Full and pop on the same edge: entry written.
  - Full and no pop: entry discarded, DROP_CNT += 1, saturating at 255.
- Pop: an edge with TS_VALID=1 and TS_READY=1 removes the head. TS_READY is ignored while TS_VALID=0.
- All-zero THERM is legal: fine=0, bubble=0. All-ones gives fine=TAPS.
- Back-to-back THERM_VLD on every cycle is supported at one entry per cycle.
- Read and write pointers have log2(DEPTH)+1 bits. Full/empty is decided by comparing pointers, and wrap-around is exact.
- TS_DATA, TS_BUBBLE and TS_VALID are driven from registers or the FIFO memory head. There is no combinational path from THERM or TS_READY.

## Timing
- Reset state (RST_N low, asynchronous): COARSE=0, TS_VALID=0, TS_DATA=0, TS_BUBBLE=0, DROP_CNT=0, FIFO empty, stage-1 valid=0.
- Release is synchronous to the first CLK edge after RST_N rises. COARSE=1 after that edge.
- Latency: THERM_VLD sampled at edge k, FIFO empty → TS_VALID=1 and TS_DATA valid after edge k+1.
- Reset asserted mid-operation: pipeline and FIFO contents are discarded, with no partial entry after release.
- Handshake: TS_DATA and TS_BUBBLE hold stable while TS_VALID=1 and TS_READY=0.
- Throughput: 1 pop per cycle sustained. A simultaneous push and pop leaves occupancy unchanged.

## Test plan
- Single hit: reset, wait until COARSE=0x10, pulse THERM_VLD with THERM=4'b0111 → after 2 edges, TS_VALID=1, TS_DATA={0x10, 3'd3}, TS_BUBBLE=0. Pop with TS_READY=1 → TS_VALID=0.
- Bubble: THERM=4'b1011 → fine=3, TS_BUBBLE=1. THERM=4'b0000 → fine=0, bubble=0. THERM=4'b1111 → fine=4, bubble=0.
- Overflow: TS_READY=0, six consecutive hits → FIFO holds the first 4 entries in order, DROP_CNT=2, TS_VALID stays 1 with the head stable.
- Full with simultaneous pop: FIFO full, TS_READY=1, one hit → the hit is stored, DROP_CNT unchanged, occupancy stays 4.
- Wrap: hit at COARSE=0xFF and hit at COARSE=0x00 → timestamps carry coarse 0xFF then 0x00. Run 3×DEPTH push/pop cycles to check pointer wrap with no loss or duplication.
- Reset mid-burst: drop RST_N while 3 entries are queued and a hit is in stage 1 → all outputs reach reset values immediately. After release, no stale entry appears and DROP_CNT=0.
